stream_downsize: RTL
====================

STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, width of one narrow output beat in bits.
REQ-002 SHALL have parameter T_DATA_RATIO, default 4, number of narrow lanes per wide input word (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_data_i  input  T_DATA_WIDTH*T_DATA_RATIO  wide input word; lane k = bits [k*T_DATA_WIDTH +: T_DATA_WIDTH].
REQ-006 SHALL have port s_keep_i  input  T_DATA_RATIO  per-lane valid mask.
REQ-007 SHALL have port s_last_i  input  1  word ends a packet.
REQ-008 SHALL have port s_valid_i  input  1  input word valid.
REQ-009 SHALL have port s_ready_o  output  1  input word accepted when s_valid_i & s_ready_o.
REQ-010 SHALL have port m_data_o  output  T_DATA_WIDTH  narrow output beat.
REQ-011 SHALL have port m_last_o  output  1  beat ends a packet.
REQ-012 SHALL have port m_valid_o  output  1  output beat valid.
REQ-013 SHALL have port m_ready_i  input  1  beat transferred when m_valid_o & m_ready_i.

Function
REQ-014 SHALL hold one accepted wide word (data, keep, last) in a holding register; FSM states IDLE (register empty) and SEND (register holds unsent kept lanes).
REQ-015 SHALL emit kept lanes in ascending lane order, lane 0 first, skipping lanes with keep=0.
REQ-016 SHALL present first beat of an accepted word on m_data_o the cycle after acceptance (latency 1); m_valid_o, m_data_o, m_last_o registered.
REQ-017 SHALL keep m_data_o, m_last_o, m_valid_o stable while m_valid_o=1 and m_ready_i=0.
REQ-018 SHALL assert m_last_o only on the highest kept lane of a word accepted with s_last_i=1.
REQ-019 SHALL drive s_ready_o=1 in IDLE, and in SEND only when the current beat is the final kept lane and m_ready_i=1 (combinational), giving zero-bubble back-to-back words.
REQ-020 SHALL transition IDLE->SEND on acceptance of a word with nonzero keep; SEND->IDLE on transfer of final kept lane with no new word accepted; SEND->SEND on transfer of final kept lane with simultaneous acceptance.
REQ-021 SHALL accept and silently discard a word with keep all zero (s_last_i discarded too), remaining in IDLE with s_ready_o=1.
REQ-022 SHALL advance the lane index only on a beat transfer; index width $clog2(T_DATA_RATIO), never wraps past last kept lane.

Reset
REQ-023 SHALL on rst_i=1 immediately clear m_valid_o=0, m_last_o=0, m_data_o=0, lane index=0, FSM=IDLE, independent of clk_i.
REQ-024 SHALL drive s_ready_o=0 while rst_i=1 and s_ready_o=1 in the first cycle after release; a word in progress at reset is dropped.

Configuration
REQ-025 SHALL honour macro STREAM_DOWNSIZE_KEEP_EN: defined -> s_keep_i used as in REQ-015/021; undefined -> s_keep_i ignored, all T_DATA_RATIO lanes emitted for every word, holding register keep bits removed.

Structure
REQ-026 SHALL take lane-index width constant, FSM state enum and lane-index typedef from shared package stream_pkg.
REQ-027 SHALL use one sub-module, lane_next_enc: combinational priority encoder returning next kept lane above current index and a "final lane" flag.

Verification (T_DATA_WIDTH=8, T_DATA_RATIO=4, KEEP_EN defined unless stated)
REQ-028 SHALL cover: data 0x44332211, keep 1111, last 1, m_ready_i=1 -> beats 11,22,33,44 on 4 consecutive cycles, m_last_o only with 44, s_ready_o high only in 44 cycle.
REQ-029 SHALL cover: data 0xDDCCBBAA, keep 0101, last 1 -> beats AA, CC; m_last_o with CC only.
REQ-030 SHALL cover: m_ready_i low 3 cycles while 22 presented -> 22 held stable, then 33, 44 follow; no beat lost or duplicated.
REQ-031 SHALL cover: two words 0x44332211, 0x88776655 back-to-back, m_ready_i=1 -> 8 beats 11..88 with no idle cycle between 44 and 55.
REQ-032 SHALL cover: rst_i pulsed mid-word after beat 22 -> m_valid_o 0 in same cycle without clock edge; after release s_ready_o=1, next word 0x0A0B0C0D emits 0D first.
REQ-033 SHALL cover: keep 0000, last 1 -> no output beat, s_ready_o stays 1; with KEEP_EN undefined same word emits 4 beats.

Source files
------------

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and constants for the stream downsizer
package stream_pkg;

    // Lane count the shared lane-index typedef is sized for
    localparam int unsigned DEFAULT_RATIO = 4;

    // Lane-index width for a given number of lanes
    function automatic int unsigned lane_idx_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int unsigned LANE_IDX_W = lane_idx_w(DEFAULT_RATIO);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ds_state_e;

endpackage

// File: rtl/lane_next_enc.sv
// rtl/lane_next_enc.sv - priority encoder for the next kept lane and final-lane flag
module lane_next_enc
    import stream_pkg::*;
#(
    parameter int unsigned RATIO = 4,
    parameter int unsigned IDX_W = lane_idx_w(RATIO)
) (
    input  logic [RATIO-1:0] keep_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             incl_i,
    output logic             found_o,
    output logic [IDX_W-1:0] next_o,
    output logic             next_final_o
);

    // Lowest kept lane above idx_i (or at idx_i when incl_i), and whether any kept lane lies above it
    always_comb begin
        found_o      = 1'b0;
        next_o       = '0;
        next_final_o = 1'b1;
        for (int k = int'(RATIO) - 1; k >= 0; k--) begin
            if (keep_i[k] && ((k > int'(idx_i)) || (incl_i && (k == int'(idx_i))))) begin
                found_o = 1'b1;
                next_o  = IDX_W'(k);
            end
        end
        for (int k = 0; k < int'(RATIO); k++) begin
            if (keep_i[k] && (k > int'(next_o))) begin
                next_final_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_downsize.sv
// rtl/stream_downsize.sv - wide-to-narrow stream downsizer; lane keep mask enabled by STREAM_DOWNSIZE_KEEP_EN
module stream_downsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned T_DATA_RATIO = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]              s_keep_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i
);

    localparam int unsigned IDX_W  = lane_idx_w(T_DATA_RATIO);
    localparam int unsigned WORD_W = T_DATA_WIDTH * T_DATA_RATIO;

    ds_state_e                state_q, state_d;
    logic [WORD_W-1:0]        data_q, data_d;
    logic                     last_q, last_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [T_DATA_WIDTH-1:0]  mdata_q, mdata_d;
    logic                     mlast_q, mlast_d;
    logic                     mvalid_q, mvalid_d;

    logic [T_DATA_RATIO-1:0]  keep_in;
    logic [T_DATA_RATIO-1:0]  keep_cur;

`ifdef STREAM_DOWNSIZE_KEEP_EN
    logic [T_DATA_RATIO-1:0]  keep_q, keep_d;

    assign keep_in  = s_keep_i;
    assign keep_cur = keep_q;
`else
    // Without the keep feature every lane is emitted, so the mask is a constant
    logic unused_keep;

    assign unused_keep = ^s_keep_i;
    assign keep_in     = '1;
    assign keep_cur    = '1;
`endif

    logic             more_found;
    logic [IDX_W-1:0] more_idx;
    logic             more_final;
    logic             first_found;
    logic [IDX_W-1:0] first_idx;
    logic             first_final;

    // Next kept lane above the beat currently presented from the holding register
    lane_next_enc #(
        .RATIO (T_DATA_RATIO),
        .IDX_W (IDX_W)
    ) u_enc_cur (
        .keep_i       (keep_cur),
        .idx_i        (idx_q),
        .incl_i       (1'b0),
        .found_o      (more_found),
        .next_o       (more_idx),
        .next_final_o (more_final)
    );

    // First kept lane of the word offered on the input
    lane_next_enc #(
        .RATIO (T_DATA_RATIO),
        .IDX_W (IDX_W)
    ) u_enc_first (
        .keep_i       (keep_in),
        .idx_i        ('0),
        .incl_i       (1'b1),
        .found_o      (first_found),
        .next_o       (first_idx),
        .next_final_o (first_final)
    );

    logic cur_final;
    logic accept;
    logic load_word;

    assign cur_final = ~more_found;
    // Ready early enough to refill the holding register in the same cycle its final beat leaves
    assign s_ready_o = ~rst_i & ((state_q == ST_IDLE) | (cur_final & m_ready_i));
    assign accept    = s_valid_i & s_ready_o;

    assign m_data_o  = mdata_q;
    assign m_last_o  = mlast_q;
    assign m_valid_o = mvalid_q;

    // Next-state and registered-output selection
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        idx_d     = idx_q;
        mdata_d   = mdata_q;
        mlast_d   = mlast_q;
        mvalid_d  = mvalid_q;
`ifdef STREAM_DOWNSIZE_KEEP_EN
        keep_d    = keep_q;
`endif
        load_word = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An all-zero keep word is accepted but produces nothing
                if (accept && first_found) begin
                    load_word = 1'b1;
                end
            end
            ST_SEND: begin
                if (m_ready_i) begin
                    if (more_found) begin
                        idx_d   = more_idx;
                        mdata_d = data_q[int'(more_idx)*int'(T_DATA_WIDTH) +: T_DATA_WIDTH];
                        mlast_d = last_q & more_final;
                    end else if (accept && first_found) begin
                        load_word = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        mvalid_d = 1'b0;
                        mlast_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_word) begin
            state_d  = ST_SEND;
            data_d   = s_data_i;
            last_d   = s_last_i;
`ifdef STREAM_DOWNSIZE_KEEP_EN
            keep_d   = s_keep_i;
`endif
            idx_d    = first_idx;
            mdata_d  = s_data_i[int'(first_idx)*int'(T_DATA_WIDTH) +: T_DATA_WIDTH];
            mlast_d  = s_last_i & first_final;
            mvalid_d = 1'b1;
        end
    end

    // State and holding register; reset drops any word in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            mdata_q  <= '0;
            mlast_q  <= 1'b0;
            mvalid_q <= 1'b0;
`ifdef STREAM_DOWNSIZE_KEEP_EN
            keep_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            mdata_q  <= mdata_d;
            mlast_q  <= mlast_d;
            mvalid_q <= mvalid_d;
`ifdef STREAM_DOWNSIZE_KEEP_EN
            keep_q   <= keep_d;
`endif
        end
    end

endmodule
